mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage core; sits between the EX/MEM pipeline register and the MEM/WB register.

---
 rtl/mem_access_stage.sv | 134 +++++++++++++
 tb/tb_mem_access_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: resolves PC redirects, runs data-RAM req/ack accesses with a timeout,
// and registers the write-back bundle for the MEM/WB register.
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc_data,
  input  logic [4:0]  in_rd_address,
  input  logic [31:0] in_alu_rd_result,
  input  logic        in_alu_rd_result_is_zero,
  input  logic [31:0] in_alu_pc_result,
  input  logic [1:0]  in_next_pc_src,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  input  logic        in_ram_wren,
  input  logic [31:0] in_store_data,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_target,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [31:0] ram_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_address,
  output logic        wb_reg_wren,
  output logic        bus_error
);
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic        access, aligned, timeout, taken;
  logic [31:0] target;

  assign access  = in_ram_wren | (in_reg_write_data_src & in_reg_wren);
  assign aligned = (in_alu_rd_result[1:0] == 2'b00);
  assign timeout = (wait_cnt == LAST);
  assign stall   = ((state == S_IDLE) & in_valid & access & aligned) |
                   ((state == S_WAIT) & ~ram_ack & ~timeout);

  always_comb begin
    taken  = 1'b0;
    target = in_alu_pc_result;
    case (in_next_pc_src)
      2'd1: taken = in_alu_rd_result_is_zero;
      2'd2: taken = 1'b1;
      2'd3: begin
        taken  = 1'b1;
        target = {in_alu_rd_result[31:1], 1'b0};
      end
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      wait_cnt           <= '0;
      pc_redirect        <= 1'b0;
      pc_redirect_target <= '0;
      ram_req            <= 1'b0;
      ram_we             <= 1'b0;
      ram_addr           <= '0;
      ram_wdata          <= '0;
      wb_valid           <= 1'b0;
      wb_pc              <= '0;
      wb_data            <= '0;
      wb_rd_address      <= '0;
      wb_reg_wren        <= 1'b0;
      bus_error          <= 1'b0;
    end else begin
      // Pulses and the write-back strobe default low every cycle.
      wb_valid    <= 1'b0;
      wb_reg_wren <= 1'b0;
      pc_redirect <= 1'b0;
      bus_error   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            wb_pc         <= in_pc_data;
            wb_rd_address <= in_rd_address;
            wb_data       <= in_alu_rd_result;
            if (access && !aligned) begin
              wb_valid  <= 1'b1;
              bus_error <= 1'b1;
            end else if (access) begin
              state     <= S_WAIT;
              wait_cnt  <= '0;
              ram_req   <= 1'b1;
              ram_we    <= in_ram_wren;
              ram_addr  <= {in_alu_rd_result[31:2], 2'b00};
              ram_wdata <= in_store_data;
            end else begin
              wb_valid           <= 1'b1;
              wb_reg_wren        <= in_reg_wren;
              pc_redirect        <= taken;
              pc_redirect_target <= target;
            end
          end
        end
        S_WAIT: begin
          // An ack arriving on the timeout cycle still completes normally.
          if (ram_ack) begin
            state       <= S_IDLE;
            ram_req     <= 1'b0;
            ram_we      <= 1'b0;
            wb_valid    <= 1'b1;
            wb_reg_wren <= in_reg_wren;
            wb_data     <= in_reg_write_data_src ? ram_rdata : in_alu_rd_result;
          end else if (timeout) begin
            state     <= S_IDLE;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            wb_valid  <= 1'b1;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads/stores, redirects,
// misalignment, timeout, ack-on-timeout and reset during an outstanding access.
module tb_mem_access_stage;
  localparam int MW = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_pc_data;
  logic [4:0]  in_rd_address;
  logic [31:0] in_alu_rd_result;
  logic        in_alu_rd_result_is_zero;
  logic [31:0] in_alu_pc_result;
  logic [1:0]  in_next_pc_src;
  logic        in_reg_write_data_src;
  logic        in_reg_wren;
  logic        in_ram_wren;
  logic [31:0] in_store_data;
  logic        stall, pc_redirect, ram_req, ram_we, ram_ack;
  logic [31:0] pc_redirect_target, ram_addr, ram_wdata, ram_rdata;
  logic        wb_valid, wb_reg_wren, bus_error;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_rd_address;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_pc_data(in_pc_data),
    .in_rd_address(in_rd_address), .in_alu_rd_result(in_alu_rd_result),
    .in_alu_rd_result_is_zero(in_alu_rd_result_is_zero), .in_alu_pc_result(in_alu_pc_result),
    .in_next_pc_src(in_next_pc_src), .in_reg_write_data_src(in_reg_write_data_src),
    .in_reg_wren(in_reg_wren), .in_ram_wren(in_ram_wren), .in_store_data(in_store_data),
    .stall(stall), .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_data(wb_data), .wb_rd_address(wb_rd_address), .wb_reg_wren(wb_reg_wren),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_valid = 0; in_pc_data = 0; in_rd_address = 0; in_alu_rd_result = 0;
    in_alu_rd_result_is_zero = 0; in_alu_pc_result = 0; in_next_pc_src = 0;
    in_reg_write_data_src = 0; in_reg_wren = 0; in_ram_wren = 0; in_store_data = 0;
    ram_ack = 0; ram_rdata = 0;
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd);
    clear_inputs();
    in_valid = 1; in_alu_rd_result = addr; in_rd_address = rd;
    in_reg_write_data_src = 1; in_reg_wren = 1; in_pc_data = 32'h300;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_pc_redirect", pc_redirect, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1;

    // ALU op, no access
    clear_inputs();
    in_valid = 1; in_rd_address = 5; in_alu_rd_result = 32'h1234; in_reg_wren = 1; in_pc_data = 32'h40;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", wb_rd_address, 5);
    chk("alu_wb_wren", wb_reg_wren, 1);
    chk("alu_wb_pc", wb_pc, 32'h40);
    chk("alu_no_redirect", pc_redirect, 0);
    in_valid = 0;
    tick();
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_wb_wren", wb_reg_wren, 0);

    // Load 0x100, ack three cycles after ram_req: stall for four cycles
    load(32'h100, 7);
    #1 chk("ld_stall_idle", stall, 1);
    tick();
    chk("ld_req", ram_req, 1);
    chk("ld_we", ram_we, 0);
    chk("ld_addr", ram_addr, 32'h100);
    chk("ld_wb_valid_wait", wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_wait", stall, 1);
      tick();
    end
    ram_ack = 1; ram_rdata = 32'hCAFEF00D;
    #1 chk("ld_stall_ack", stall, 0);
    tick();
    clear_inputs();
    chk("ld_req_drop", ram_req, 0);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 32'hCAFEF00D);
    chk("ld_wb_wren", wb_reg_wren, 1);
    chk("ld_wb_rd", wb_rd_address, 7);

    // Store 0x104 data 0x55, ack in first WAIT cycle
    in_valid = 1; in_alu_rd_result = 32'h104; in_ram_wren = 1; in_store_data = 32'h55;
    tick();
    chk("st_req", ram_req, 1);
    chk("st_we", ram_we, 1);
    chk("st_addr", ram_addr, 32'h104);
    chk("st_wdata", ram_wdata, 32'h55);
    ram_ack = 1;
    #1 chk("st_stall_ack", stall, 0);
    tick();
    clear_inputs();
    chk("st_req_drop", ram_req, 0);
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_wren", wb_reg_wren, 0);

    // Branch taken / not taken, jump-register target LSB cleared
    in_valid = 1; in_next_pc_src = 1; in_alu_rd_result_is_zero = 1; in_alu_pc_result = 32'h80;
    tick();
    chk("br_taken", pc_redirect, 1);
    chk("br_target", pc_redirect_target, 32'h80);
    in_alu_rd_result_is_zero = 0;
    tick();
    chk("br_not_taken", pc_redirect, 0);
    chk("br_nt_wb_valid", wb_valid, 1);
    in_next_pc_src = 3; in_alu_rd_result = 32'h203;
    tick();
    chk("jr_taken", pc_redirect, 1);
    chk("jr_target", pc_redirect_target, 32'h202);
    clear_inputs();
    tick();
    chk("redirect_pulse_end", pc_redirect, 0);

    // Misaligned load
    load(32'h102, 3);
    #1 chk("mis_stall", stall, 0);
    tick();
    clear_inputs();
    chk("mis_bus_error", bus_error, 1);
    chk("mis_no_req", ram_req, 0);
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_wb_wren", wb_reg_wren, 0);
    tick();
    chk("mis_err_pulse_end", bus_error, 0);

    // Load with no ack: abort after MW cycles in WAIT
    load(32'h200, 9);
    tick();
    for (int i = 0; i < MW - 1; i++) begin
      chk("to_stall_wait", stall, 1);
      chk("to_req_held", ram_req, 1);
      tick();
    end
    chk("to_stall_last", stall, 0);
    tick();
    clear_inputs();
    chk("to_req_drop", ram_req, 0);
    chk("to_bus_error", bus_error, 1);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_wren", wb_reg_wren, 0);

    // Ack on the timeout cycle completes normally
    load(32'h208, 10);
    tick();
    for (int i = 0; i < MW - 1; i++) tick();
    ram_ack = 1; ram_rdata = 32'h0BADBEEF;
    tick();
    clear_inputs();
    chk("ackto_bus_error", bus_error, 0);
    chk("ackto_wb_data", wb_data, 32'h0BADBEEF);
    chk("ackto_wb_wren", wb_reg_wren, 1);

    // Reset during WAIT, then a late ack
    load(32'h300, 11);
    tick(); tick();
    chk("rw_req_before", ram_req, 1);
    reset_n = 0;
    tick();
    chk("rw_req_reset", ram_req, 0);
    chk("rw_wb_valid_reset", wb_valid, 0);
    reset_n = 1; in_valid = 0; ram_ack = 1; ram_rdata = 32'h12345678;
    #1 chk("rw_stall_late", stall, 0);
    tick();
    ram_ack = 0;
    chk("rw_late_wb_valid", wb_valid, 0);
    chk("rw_late_req", ram_req, 0);
    chk("rw_late_wb_data", wb_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
